lb_uart: RTL and testbench
==========================

Name: lb_uart

Overview:
- UART peripheral that sits as one slave on the low-speed bus, directly downstream of the low-speed bus bridge.
- Consumes the bridge's `lb_slave_t` request and returns its read word on one `lb_data_in[i]` lane.
- The bridge ORs all slave lanes together, so this block drives exactly zero whenever it is not the addressed target of an active read.
- Provides a TX FIFO, a single-entry RX holding register, and a programmable baud divider.

Parameters:
- BASE_ADDR, 0, byte base address of the 16-byte register window; bits [3:0] must be 0.
- TX_DEPTH, 8, TX FIFO depth in bytes; power of two, 2..64.
- DEFAULT_DIV, 16'd104, reset value of the baud divider (lb_clk cycles per bit).

Ports:
- lb_clk  input  1  low-speed bus clock; all logic is in this domain.
- rst  input  1  synchronous, active-high reset.
- bus  input  lb_slave_t  low-speed bus request: ren, wen, addr[LB_ADDR_WIDTH], wdata[32], write_width[2].
- rdata  output  32  read lane into the bridge's OR-mux; 0 unless this block is selected by an active ren.
- uart_tx  output  1  serial out; idle high.
- uart_rx  input  1  serial in; asynchronous.
- irq  output  1  high while `rx_valid` or (`tx_empty` and `TXIE`).

Behaviour:
- Bus framing and decode:
  - ren and wen are single-cycle pulses and are never asserted together.
  - sel = `addr[LB_ADDR_WIDTH-1:4] == BASE_ADDR[LB_ADDR_WIDTH-1:4]`.
  - Register offset = `addr[3:2]`; `addr[1:0]` is ignored.
- Read timing:
  - rdata is combinational from (ren & sel, offset, state) and is valid in the same cycle ren is high; the bridge samples it at the next edge.
  - Read side effects (RX pop) take effect at that same edge.
- Write widths: `write_width` 0 = byte, 1 = halfword, 2 = word.
  - Byte and halfword writes update only the low 8 or 16 bits of the target register; the remaining bits are unchanged.
- Registers:
  - 0x0 DATA.
    - Write: push `wdata[7:0]` into the TX FIFO. If the FIFO is full, the write is dropped and `tx_ovf` is set.
    - Read: returns `{23'b0, rx_valid, rx_byte}`. If `rx_valid` is set, it clears at the edge ending the read.
  - 0x4 STATUS (read-only; writes ignored): `{26'b0, tx_ovf, rx_ovr, tx_busy, tx_empty, tx_full, rx_valid}`.
  - 0x8 CTRL (R/W).
    - [15:0] DIV; values below 4 are clamped to 4 internally.
    - [16] TXIE.
    - [17] LOOP: `uart_rx` is replaced by internal `uart_tx`.
  - 0xC CLR (write-only; reads return 0): writing 1 to bit0 clears `rx_ovr`; writing 1 to bit1 clears `tx_ovf`.
- Reset values:
  - `rdata` = 0, `uart_tx` = 1, `irq` = 0.
  - FIFO empty, DIV = DEFAULT_DIV, TXIE = 0, LOOP = 0.
  - All flags 0; both FSMs in IDLE.
- TX FSM: states IDLE, START, DATA, STOP.
  - IDLE → START when the FIFO is non-empty; pop the byte into a shift register.
  - Each state lasts exactly DIV cycles, counted by the bit counter.
  - START drives 0; DATA drives 8 bits LSB first; STOP drives 1.
  - After STOP → IDLE, then start the next frame on the following cycle if the FIFO is non-empty (back-to-back frames).
  - `tx_busy` = state != IDLE.
- RX FSM: states IDLE, START, DATA, STOP.
  - `uart_rx` passes through a 2-flop synchronizer, reset to 1.
  - A falling edge in IDLE → START. At DIV/2 cycles, re-sample: if high (glitch) → IDLE; otherwise continue.
  - Sample each data bit every DIV cycles after that, then the stop bit.
  - Stop bit = 1: load `rx_byte` and set `rx_valid`. If `rx_valid` was already set, set `rx_ovr` and overwrite `rx_byte`.
  - Stop bit = 0: discard the frame (framing error); no flags change.
- Simultaneous events:
  - Bus push and TX pop in the same cycle on a full FIFO: both succeed and the count is unchanged.
  - RX load and DATA-read pop in the same cycle: the load wins, `rx_valid` stays 1, and `rx_ovr` is not set.
- Changing DIV mid-frame: the new value takes effect at the next bit boundary.
- `rst` mid-frame: `uart_tx` returns to 1 on the next cycle, the FIFO is flushed, and any partial RX frame is dropped.

Decomposition:
- Package `XT_LB_UART` (or an addition to `XT_BUS`): register offset localparams, STATUS/CTRL bit index constants, and the TX/RX state enums.
- One sub-module: `sync_fifo`, with parameters WIDTH and DEPTH and ports push/pop/full/empty/count.
  - Pop data is combinational from the head; push to a full FIFO and pop from an empty FIFO are ignored.

Test Plan:
- Reset, set DIV = 4, write 0x55 to DATA (byte) → `uart_tx` shows 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles wide, 40 cycles total; then `tx_busy` = 0 and `tx_empty` = 1.
- LOOP = 1, DIV = 4, write 0xA3 → `irq` rises after the frame; DATA read returns 0x1A3; the next DATA read returns 0x0A3 with `rx_valid` = 0.
- Write 9 bytes back-to-back with TX_DEPTH = 8 while the TX FSM has already popped the first → no drop. Then fill to full and write once more → `tx_ovf` = 1 and the byte is lost; CLR bit1 clears it.
- Drive two external RX frames 0x11 and 0x22 with no read in between → DATA reads 0x122 and STATUS shows `rx_ovr` = 1. Also drive a 2-cycle low glitch at DIV = 8 → no frame is received.
- Read at addresses outside the window and while ren = 0 → `rdata` = 0 every cycle. Halfword write 0x0008 to CTRL with CTRL = 0x30010 → CTRL = 0x30008.
- Assert `rst` mid-DATA bit → next cycle `uart_tx` = 1, `tx_empty` = 1, DIV = DEFAULT_DIV, and `irq` = 0.

Source files
------------

// File: rtl/lb_uart_pkg.sv
// Shared types and constants for the low-speed bus UART: bus request layout,
// register map, bit positions and the TX/RX state encodings.
package lb_uart_pkg;

  localparam int LB_ADDR_WIDTH = 16;

  typedef struct packed {
    logic                     ren;
    logic                     wen;
    logic [LB_ADDR_WIDTH-1:0] addr;
    logic [31:0]              wdata;
    logic [1:0]               write_width;
  } lb_slave_t;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;
  localparam logic [1:0] OFF_CLR    = 2'd3;

  localparam int ST_RX_VALID = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_TX_BUSY  = 3;
  localparam int ST_RX_OVR   = 4;
  localparam int ST_TX_OVF   = 5;

  localparam int CTRL_TXIE = 16;
  localparam int CTRL_LOOP = 17;

  localparam int CLR_RX_OVR = 0;
  localparam int CLR_TX_OVF = 1;

  localparam logic [15:0] DIV_MIN = 16'd4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Sub-word writes only replace the low byte/halfword of the target register.
  function automatic logic [31:0] merge_write(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  width);
    case (width)
      2'd0:    merge_write = {old_val[31:8], wdata[7:0]};
      2'd1:    merge_write = {old_val[31:16], wdata[15:0]};
      default: merge_write = wdata;
    endcase
  endfunction

endpackage

// File: rtl/lb_uart_sync_fifo.sv
// Single-clock FIFO with combinational head data. A push on a full FIFO is
// accepted only when a pop happens in the same cycle.
module lb_uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     lb_clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);

  always_ff @(posedge lb_clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge lb_clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lb_uart.sv
// Low-speed bus UART slave: TX FIFO, single-entry RX holding register and a
// programmable baud divider; read lane is zero unless addressed by a read.
//
// state    | meaning
// IDLE     | line idle high; TX waits for FIFO data, RX waits for a falling edge
// START    | start bit; RX re-checks the line at mid-bit to reject glitches
// DATA     | 8 data bits, LSB first, one per divider period
// STOP     | stop bit; RX commits the byte only if the line is high
module lb_uart
  import lb_uart_pkg::*;
#(
  parameter logic [LB_ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                       TX_DEPTH    = 8,
  parameter logic [15:0]              DEFAULT_DIV = 16'd104
) (
  input  logic        lb_clk,
  input  logic        rst,
  input  lb_slave_t   bus,
  output logic [31:0] rdata,
  output logic        uart_tx,
  input  logic        uart_rx,
  output logic        irq
);

  logic        sel, rd, wr;
  logic [1:0]  off;
  logic [17:0] ctrl;
  logic [31:0] ctrl_wr;
  logic [15:0] div_eff, div_m1, half_m1;
  logic        rx_valid, rx_ovr, tx_ovf;
  logic [7:0]  rx_byte;

  logic        fifo_push, fifo_full, fifo_empty, tx_pop;
  logic [7:0]  fifo_head;
  logic [$clog2(TX_DEPTH):0] fifo_count;

  tx_state_t   tx_state, tx_state_d;
  logic [15:0] tx_cnt, tx_cnt_d;
  logic [2:0]  tx_bit, tx_bit_d;
  logic [7:0]  tx_sh, tx_sh_d;

  rx_state_t   rx_state, rx_state_d;
  logic [15:0] rx_cnt, rx_cnt_d;
  logic [2:0]  rx_bit, rx_bit_d;
  logic [7:0]  rx_sh, rx_sh_d;
  logic        rx_meta, rx_s, rx_prev, rx_load, rx_pop;

  logic        unused;
  assign unused = ^{bus.addr[1:0], ctrl_wr[31:18], fifo_count};

  assign sel = (bus.addr[LB_ADDR_WIDTH-1:4] == BASE_ADDR[LB_ADDR_WIDTH-1:4]);
  assign off = bus.addr[3:2];
  assign rd  = bus.ren & sel;
  assign wr  = bus.wen & sel;

  assign div_eff = (ctrl[15:0] < DIV_MIN) ? DIV_MIN : ctrl[15:0];
  assign div_m1  = div_eff - 16'd1;
  assign half_m1 = (div_eff >> 1) - 16'd1;
  assign ctrl_wr = merge_write({14'b0, ctrl}, bus.wdata, bus.write_width);

  assign fifo_push = wr & (off == OFF_DATA);
  assign rx_pop    = rd & (off == OFF_DATA);

  lb_uart_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .lb_clk    (lb_clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (bus.wdata[7:0]),
    .pop       (tx_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    rdata = '0;
    if (rd) begin
      case (off)
        OFF_DATA:   rdata = {23'b0, rx_valid, rx_byte};
        OFF_STATUS: rdata = {26'b0, tx_ovf, rx_ovr, (tx_state != TX_IDLE),
                             fifo_empty, fifo_full, rx_valid};
        OFF_CTRL:   rdata = {14'b0, ctrl};
        default:    rdata = '0;
      endcase
    end
  end

  assign irq     = rx_valid | (fifo_empty & ctrl[CTRL_TXIE]);
  assign uart_tx = (tx_state == TX_START) ? 1'b0 :
                   (tx_state == TX_DATA)  ? tx_sh[0] : 1'b1;

  // TX: bit timer reloads from the current divider at every bit boundary.
  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt;
    tx_bit_d   = tx_bit;
    tx_sh_d    = tx_sh;
    tx_pop     = 1'b0;
    case (tx_state)
      TX_IDLE: if (!fifo_empty) begin
        tx_pop     = 1'b1;
        tx_sh_d    = fifo_head;
        tx_cnt_d   = div_m1;
        tx_state_d = TX_START;
      end
      TX_START: if (tx_cnt == '0) begin
        tx_cnt_d   = div_m1;
        tx_bit_d   = '0;
        tx_state_d = TX_DATA;
      end else tx_cnt_d = tx_cnt - 16'd1;
      TX_DATA: if (tx_cnt == '0) begin
        tx_cnt_d = div_m1;
        if (tx_bit == 3'd7) tx_state_d = TX_STOP;
        else begin
          tx_bit_d = tx_bit + 3'd1;
          tx_sh_d  = tx_sh >> 1;
        end
      end else tx_cnt_d = tx_cnt - 16'd1;
      TX_STOP: if (tx_cnt == '0) tx_state_d = TX_IDLE;
               else tx_cnt_d = tx_cnt - 16'd1;
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    rx_state_d = rx_state;
    rx_cnt_d   = rx_cnt;
    rx_bit_d   = rx_bit;
    rx_sh_d    = rx_sh;
    rx_load    = 1'b0;
    case (rx_state)
      RX_IDLE: if (rx_prev && !rx_s) begin
        rx_cnt_d   = half_m1;
        rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt == '0) begin
        rx_cnt_d   = div_m1;
        rx_bit_d   = '0;
        rx_state_d = rx_s ? RX_IDLE : RX_DATA;
      end else rx_cnt_d = rx_cnt - 16'd1;
      RX_DATA: if (rx_cnt == '0) begin
        rx_sh_d  = {rx_s, rx_sh[7:1]};
        rx_cnt_d = div_m1;
        if (rx_bit == 3'd7) rx_state_d = RX_STOP;
        else rx_bit_d = rx_bit + 3'd1;
      end else rx_cnt_d = rx_cnt - 16'd1;
      RX_STOP: if (rx_cnt == '0) begin
        rx_load    = rx_s;
        rx_state_d = RX_IDLE;
      end else rx_cnt_d = rx_cnt - 16'd1;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge lb_clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      rx_prev  <= 1'b1;
    end else begin
      tx_state <= tx_state_d;
      tx_cnt   <= tx_cnt_d;
      tx_bit   <= tx_bit_d;
      tx_sh    <= tx_sh_d;
      rx_state <= rx_state_d;
      rx_cnt   <= rx_cnt_d;
      rx_bit   <= rx_bit_d;
      rx_sh    <= rx_sh_d;
      rx_meta  <= ctrl[CTRL_LOOP] ? uart_tx : uart_rx;
      rx_s     <= rx_meta;
      rx_prev  <= rx_s;
    end
  end

  // A load in the same cycle as a DATA read keeps rx_valid and is no overrun.
  always_ff @(posedge lb_clk) begin
    if (rst) begin
      ctrl     <= {2'b00, DEFAULT_DIV};
      rx_valid <= 1'b0;
      rx_byte  <= '0;
      rx_ovr   <= 1'b0;
      tx_ovf   <= 1'b0;
    end else begin
      if (wr && off == OFF_CTRL) ctrl <= ctrl_wr[17:0];
      if (rx_load) begin
        rx_valid <= 1'b1;
        rx_byte  <= rx_sh;
      end else if (rx_pop) begin
        rx_valid <= 1'b0;
      end
      if (rx_load && rx_valid && !rx_pop) rx_ovr <= 1'b1;
      else if (wr && off == OFF_CLR && bus.wdata[CLR_RX_OVR]) rx_ovr <= 1'b0;
      if (fifo_push && fifo_full && !tx_pop) tx_ovf <= 1'b1;
      else if (wr && off == OFF_CLR && bus.wdata[CLR_TX_OVF]) tx_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lb_uart.sv
// Directed self-checking bench for lb_uart: framing, loopback, FIFO overflow,
// RX overrun/glitch rejection, address decode and mid-frame reset.
module tb_lb_uart;
  import lb_uart_pkg::*;

  logic        lb_clk = 1'b0;
  logic        rst;
  lb_slave_t   bus;
  logic [31:0] rdata;
  logic        uart_tx;
  logic        uart_rx;
  logic        irq;

  int checks = 0;
  int errors = 0;

  lb_uart #(.BASE_ADDR(16'h0000), .TX_DEPTH(8), .DEFAULT_DIV(16'd104)) dut (
    .lb_clk  (lb_clk),
    .rst     (rst),
    .bus     (bus),
    .rdata   (rdata),
    .uart_tx (uart_tx),
    .uart_rx (uart_rx),
    .irq     (irq)
  );

  always #5 lb_clk = ~lb_clk;

  // Bus tasks assume they start at posedge+1 and leave at the next posedge+1.
  task automatic bus_write(input logic [15:0] addr, input logic [31:0] data,
                           input logic [1:0] width);
    bus.wen = 1'b1; bus.addr = addr; bus.wdata = data; bus.write_width = width;
    @(posedge lb_clk); #1;
    bus.wen = 1'b0; bus.wdata = '0;
  endtask

  task automatic bus_read(input logic [15:0] addr, output logic [31:0] data);
    bus.ren = 1'b1; bus.addr = addr;
    #1 data = rdata;
    @(posedge lb_clk); #1;
    bus.ren = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge lb_clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b, input int period);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = fr[i];
      cycles(period);
    end
  endtask

  task automatic test_reset;
    logic [31:0] d;
    rst = 1'b1;
    cycles(3);
    if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    checks++;
    if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", uart_tx); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
    checks++;
    rst = 1'b0;
    bus_read(16'h0004, d);
    if (d !== 32'h4) begin errors++; $display("FAIL reset_status: got %h want 4", d); end
    checks++;
    bus_read(16'h0008, d);
    if (d !== 32'h68) begin errors++; $display("FAIL reset_ctrl: got %h want 68", d); end
    checks++;
  endtask

  task automatic test_tx_frame;
    logic [31:0] d;
    logic [9:0]  fr;
    fr = {1'b1, 8'h55, 1'b0};
    bus_write(16'h0008, 32'h4, 2'd2);
    bus_write(16'h0000, 32'h55, 2'd0);
    cycles(1);
    for (int i = 0; i < 40; i++) begin
      if (uart_tx !== fr[i/4]) begin
        errors++; $display("FAIL tx_bit cycle %0d: got %b want %b", i, uart_tx, fr[i/4]);
      end
      checks++;
      cycles(1);
    end
    bus_read(16'h0004, d);
    if (d !== 32'h4) begin errors++; $display("FAIL tx_done_status: got %h want 4", d); end
    checks++;
  endtask

  task automatic test_loopback;
    logic [31:0] d;
    bus_write(16'h0008, 32'h20004, 2'd2);
    bus_write(16'h0000, 32'hA3, 2'd0);
    for (int i = 0; i < 200; i++) begin
      if (irq === 1'b1) break;
      cycles(1);
    end
    if (irq !== 1'b1) begin errors++; $display("FAIL loop_irq: got %b want 1", irq); end
    checks++;
    bus_read(16'h0000, d);
    if (d !== 32'h1A3) begin errors++; $display("FAIL loop_data1: got %h want 1a3", d); end
    checks++;
    bus_read(16'h0000, d);
    if (d !== 32'h0A3) begin errors++; $display("FAIL loop_data2: got %h want 0a3", d); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL loop_irq_clr: got %b want 0", irq); end
    checks++;
  endtask

  task automatic test_rx_overrun;
    logic [31:0] d;
    bus_write(16'h0008, 32'h4, 2'd2);
    send_rx(8'h11, 4);
    send_rx(8'h22, 4);
    cycles(4);
    bus_read(16'h0004, d);
    if (d !== 32'h15) begin errors++; $display("FAIL ovr_status: got %h want 15", d); end
    checks++;
    bus_read(16'h0000, d);
    if (d !== 32'h122) begin errors++; $display("FAIL ovr_data: got %h want 122", d); end
    checks++;
    bus_write(16'h000C, 32'h1, 2'd2);
    bus_read(16'h0004, d);
    if (d !== 32'h4) begin errors++; $display("FAIL ovr_clr: got %h want 4", d); end
    checks++;
  endtask

  task automatic test_glitch;
    logic [31:0] d;
    bus_write(16'h0008, 32'h8, 2'd2);
    uart_rx = 1'b0;
    cycles(2);
    uart_rx = 1'b1;
    cycles(40);
    bus_read(16'h0004, d);
    if (d !== 32'h4) begin errors++; $display("FAIL glitch_status: got %h want 4", d); end
    checks++;
    send_rx(8'h5A, 8);
    cycles(6);
    bus_read(16'h0000, d);
    if (d !== 32'h15A) begin errors++; $display("FAIL div8_data: got %h want 15a", d); end
    checks++;
  endtask

  task automatic test_decode;
    logic [31:0] d;
    logic [15:0] addrs [3];
    addrs[0] = 16'h0010; addrs[1] = 16'h0014; addrs[2] = 16'h1008;
    bus.addr = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (rdata !== 32'h0) begin errors++; $display("FAIL idle_rdata %0d: got %h want 0", i, rdata); end
      checks++;
      cycles(1);
    end
    for (int i = 0; i < 3; i++) begin
      bus_read(addrs[i], d);
      if (d !== 32'h0) begin errors++; $display("FAIL window_rdata %h: got %h want 0", addrs[i], d); end
      checks++;
    end
    bus_write(16'h0008, 32'h30010, 2'd2);
    if (irq !== 1'b1) begin errors++; $display("FAIL txie_irq: got %b want 1", irq); end
    checks++;
    bus_write(16'h0008, 32'hFFFF0008, 2'd1);
    bus_read(16'h0008, d);
    if (d !== 32'h30008) begin errors++; $display("FAIL ctrl_half: got %h want 30008", d); end
    checks++;
    bus_write(16'h0008, 32'h12345604, 2'd0);
    bus_read(16'h0008, d);
    if (d !== 32'h30004) begin errors++; $display("FAIL ctrl_byte: got %h want 30004", d); end
    checks++;
    bus_write(16'h0004, 32'hFF, 2'd2);
    bus_read(16'h000C, d);
    if (d !== 32'h0) begin errors++; $display("FAIL clr_read: got %h want 0", d); end
    checks++;
    bus_write(16'h0008, 32'h4, 2'd2);
  endtask

  task automatic test_fifo_ovf;
    logic [31:0] d;
    for (int i = 1; i <= 9; i++) bus_write(16'h0000, 32'(i), 2'd0);
    bus_read(16'h0004, d);
    if (d !== 32'h0A) begin errors++; $display("FAIL fifo_full_status: got %h want 0a", d); end
    checks++;
    bus_write(16'h0000, 32'hEE, 2'd0);
    bus_read(16'h0004, d);
    if (d !== 32'h2A) begin errors++; $display("FAIL fifo_ovf_status: got %h want 2a", d); end
    checks++;
    bus_write(16'h000C, 32'h2, 2'd0);
    bus_read(16'h0004, d);
    if (d !== 32'h0A) begin errors++; $display("FAIL fifo_ovf_clr: got %h want 0a", d); end
    checks++;
  endtask

  task automatic test_reset_midframe;
    logic [31:0] d;
    cycles(8);
    bus_read(16'h0004, d);
    if (d[ST_TX_BUSY] !== 1'b1) begin errors++; $display("FAIL midframe_busy: got %b want 1", d[ST_TX_BUSY]); end
    checks++;
    rst = 1'b1;
    cycles(1);
    if (uart_tx !== 1'b1) begin errors++; $display("FAIL rst_tx: got %b want 1", uart_tx); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b want 0", irq); end
    checks++;
    rst = 1'b0;
    bus_read(16'h0004, d);
    if (d !== 32'h4) begin errors++; $display("FAIL rst_status: got %h want 4", d); end
    checks++;
    bus_read(16'h0008, d);
    if (d !== 32'h68) begin errors++; $display("FAIL rst_ctrl: got %h want 68", d); end
    checks++;
  endtask

  initial begin
    rst = 1'b1;
    uart_rx = 1'b1;
    bus = '0;
    @(posedge lb_clk); #1;
    test_reset();
    test_tx_frame();
    test_loopback();
    test_rx_overrun();
    test_glitch();
    test_decode();
    test_fifo_ovf();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
